// File: rtl/beat_pkg.sv
// beat_pkg: types and constants shared by the beat sequencer and its pattern
// memory.
//   TEMPO_W      width of a tempo-select code for the beat generator
//   BEATS_MAX_W  storage width of the per-entry beat count; the sequencer's
//                BEAT_W must not exceed it (narrower counts are zero-extended)
//   state_t      sequencer FSM states
//   beat_entry_t one pattern-table entry {tempo, beats}
package beat_pkg;

  localparam int TEMPO_W     = 3;
  localparam int BEATS_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [TEMPO_W-1:0]     tempo;
    logic [BEATS_MAX_W-1:0] beats;
  } beat_entry_t;

endpackage

// File: rtl/beat_pattern_mem.sv
// beat_pattern_mem: DEPTH-entry pattern table for the beat sequencer.
// Synchronous write, combinational read, every entry cleared on reset.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   we          write strobe (already qualified by the caller)
//   waddr/wdata entry index and contents to store
//   raddr/rdata entry index to read and its current contents
module beat_pattern_mem
  import beat_pkg::*;
#(
  parameter int  DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  beat_entry_t       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output beat_entry_t       rdata
);

  beat_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is combinational so a write landing on the start cycle is already
  // visible when the first FETCH indexes the table.
  assign rdata = mem[raddr];

endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: plays a programmable table of {tempo, beat count} steps into
// a beat generator. Each step selects a tempo on S, releases the generator
// reset, counts rising edges of the generator pulse and then advances to the
// next step, optionally looping back to step 0.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_we/addr/tempo/beats  pattern-entry write (accepted only while idle)
//   cfg_ack               registered one-cycle acknowledge of an accepted write
//   seq_len               steps to play, 1..DEPTH (latched on start)
//   loop                  restart at step 0 after the last step (latched)
//   start, stop           begin (idle only) / abort the sequence
//   beat_pulse            pulse output of the beat generator
//   S                     tempo select to the generator
//   gen_reset             reset to the generator (low only while running)
//   step                  current step index
//   busy                  sequence active (FETCH or RUN)
//   done                  one-cycle end-of-sequence strobe (non-loop only)
//   beat_tick             one-cycle strobe per counted beat, one cycle late
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter int  BEAT_W = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [TEMPO_W-1:0] cfg_tempo,
  input  logic [BEAT_W-1:0]  cfg_beats,
  output logic               cfg_ack,
  input  logic [ADDR_W:0]    seq_len,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  input  logic               beat_pulse,
  output logic [TEMPO_W-1:0] S,
  output logic               gen_reset,
  output logic [ADDR_W-1:0]  step,
  output logic               busy,
  output logic               done,
  output logic               beat_tick
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  // Down-counter decrement that holds at zero instead of wrapping.
  function automatic logic [BEAT_W-1:0] dec_sat(input logic [BEAT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  step_q, step_nx;
  logic [ADDR_W:0]    len_m1_q, len_m1_nx;
  logic               loop_q, loop_nx;
  logic [TEMPO_W-1:0] s_q, s_nx;
  logic [BEAT_W-1:0]  rem_q, rem_nx;
  logic               tick_q, tick_nx;
  logic               ack_q;
  logic               beat_pulse_p1;

  logic               mem_we;
  beat_entry_t        wr_entry;
  beat_entry_t        rd_entry;
  logic               beats_zero;
  logic               seq_ok;
  logic               edge_det;
  logic               last_step;
  state_t             end_state;
  logic [ADDR_W-1:0]  end_step;

  // ---------------------------------------------------------------------------
  // Pattern table: writes only while idle, read at the current step
  // ---------------------------------------------------------------------------
  assign mem_we         = cfg_we && (state == IDLE);
  assign wr_entry.tempo = cfg_tempo;
  assign wr_entry.beats = BEATS_MAX_W'(cfg_beats);

  beat_pattern_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wdata (wr_entry),
    .raddr (step_q),
    .rdata (rd_entry)
  );

  assign beats_zero = (rd_entry.beats == '0);
  assign seq_ok     = (seq_len != '0) && (seq_len <= DEPTH_L);

  // Only a low-to-high transition counts, so a wide generator pulse is one beat.
  assign edge_det   = beat_pulse & ~beat_pulse_p1;

  // Step-end rule, shared by a skipped step in FETCH and the final beat in RUN.
  assign last_step  = ({1'b0, step_q} >= len_m1_q);
  assign end_state  = (last_step && !loop_q) ? DONE : FETCH;
  always_comb begin
    end_step = step_q + 1'b1;
    if (last_step) begin
      end_step = loop_q ? '0 : step_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    step_nx   = step_q;
    len_m1_nx = len_m1_q;
    loop_nx   = loop_q;
    s_nx      = s_q;
    rem_nx    = rem_q;
    tick_nx   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && seq_ok) begin
          state_nx  = FETCH;
          step_nx   = '0;
          len_m1_nx = seq_len - 1'b1;
          loop_nx   = loop;
        end
      end

      FETCH: begin
        if (stop) begin
          state_nx = IDLE;
        end else begin
          s_nx = rd_entry.tempo;
          if (beats_zero) begin
            // A zero-beat step costs just this FETCH cycle.
            state_nx = end_state;
            step_nx  = end_step;
          end else begin
            state_nx = RUN;
            rem_nx   = rd_entry.beats[BEAT_W-1:0];
          end
        end
      end

      RUN: begin
        // Stop wins over a beat edge in the same cycle: no tick, no advance.
        if (stop) begin
          state_nx = IDLE;
        end else if (edge_det) begin
          rem_nx  = dec_sat(rem_q);
          tick_nx = 1'b1;
          if (rem_q == BEAT_W'(1)) begin
            state_nx = end_state;
            step_nx  = end_step;
          end
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // The generator always sees tempo 0 while the sequencer is idle.
    if (state_nx == IDLE) begin
      s_nx = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      step_q        <= '0;
      len_m1_q      <= '0;
      loop_q        <= 1'b0;
      s_q           <= '0;
      rem_q         <= '0;
      tick_q        <= 1'b0;
      ack_q         <= 1'b0;
      beat_pulse_p1 <= 1'b0;
    end else begin
      state         <= state_nx;
      step_q        <= step_nx;
      len_m1_q      <= len_m1_nx;
      loop_q        <= loop_nx;
      s_q           <= s_nx;
      rem_q         <= rem_nx;
      tick_q        <= tick_nx;
      ack_q         <= mem_we;
      beat_pulse_p1 <= beat_pulse;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign S         = s_q;
  assign step      = step_q;
  assign busy      = (state == FETCH) || (state == RUN);
  assign gen_reset = (state != RUN);
  assign done      = (state == DONE);
  assign beat_tick = tick_q;
  assign cfg_ack   = ack_q;

endmodule

// File: tb/tb_beat_sequencer.sv
`timescale 1ns/1ps
module tb_beat_sequencer;

  localparam int DEPTH  = 8;
  localparam int BEAT_W = 8;
  localparam int ADDR_W = 3;
  localparam int MAXC   = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [2:0]        cfg_tempo;
  logic [BEAT_W-1:0] cfg_beats;
  logic              cfg_ack;
  logic [ADDR_W:0]   seq_len;
  logic              loop;
  logic              start;
  logic              stop;
  logic              beat_pulse;
  logic [2:0]        S;
  logic              gen_reset;
  logic [ADDR_W-1:0] step;
  logic              busy;
  logic              done;
  logic              beat_tick;

  beat_sequencer #(.DEPTH(DEPTH), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_tempo(cfg_tempo), .cfg_beats(cfg_beats),
    .cfg_ack(cfg_ack), .seq_len(seq_len), .loop(loop), .start(start), .stop(stop),
    .beat_pulse(beat_pulse), .S(S), .gen_reset(gen_reset), .step(step), .busy(busy),
    .done(done), .beat_tick(beat_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference pattern table
  int m_tempo [DEPTH];
  int m_beats [DEPTH];

  // Expected per-cycle behaviour of one run (cycle 0 = the start cycle)
  int e_busy [MAXC], e_grst [MAXC], e_s [MAXC], e_step [MAXC];
  int e_done [MAXC], e_tick [MAXC], e_ack [MAXC];
  bit s_care [MAXC], step_care [MAXC];
  // Stimulus of one run
  bit pul [MAXC];
  bit d_we [MAXC], d_start [MAXC], d_stop [MAXC], d_loop [MAXC];
  int d_addr [MAXC], d_tempo [MAXC], d_beats [MAXC], d_len [MAXC];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    cfg_we = 1'b0; cfg_addr = '0; cfg_tempo = '0; cfg_beats = '0;
    seq_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0; beat_pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_tempo = 3'd5; cfg_beats = 8'd9;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    quiet_inputs();
    @(negedge clk);
    check_val("rst_S", S, 0);
    check_val("rst_gen_reset", gen_reset, 1);
    check_val("rst_step", step, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_beat_tick", beat_tick, 0);
    check_val("rst_cfg_ack", cfg_ack, 0);
    for (int i = 0; i < DEPTH; i++) begin
      m_tempo[i] = 0;
      m_beats[i] = 0;
    end
    next_cycle();
  endtask

  task automatic cfg_write(input int a, input int t, input int b);
    cfg_we = 1'b1; cfg_addr = a[ADDR_W-1:0]; cfg_tempo = t[2:0]; cfg_beats = b[BEAT_W-1:0];
    next_cycle();
    cfg_we = 1'b0;
    @(negedge clk);
    check_val("cfg_ack_idle", cfg_ack, 1);
    m_tempo[a] = t;
    m_beats[a] = b;
    next_cycle();
  endtask

  function automatic bit pulse_edge(input int c);
    return pul[c] && (c == 0 || !pul[c-1]);
  endfunction

  function automatic void set_idle(input int k);
    e_busy[k] = 0; e_grst[k] = 1; e_s[k] = 0; s_care[k] = 1;
    e_step[k] = 0; step_care[k] = 0; e_done[k] = 0; e_tick[k] = 0;
  endfunction

  // One sequence: start in cycle 0 with the given length/loop, generator pulses
  // of the given period/width, and an optional stop.
  //   stop_sel: -1 none, -2 on the final beat edge, -3 random cycle, >=1 that cycle
  task automatic run_seq(input int len, input bit lp, input int period, input int width,
                         input int stop_sel, input bit rand_io);
    int phase, t, st, c, cnt, done_cyc, stop_at, last, endc, sum_beats;
    int obs_ticks, obs_done;
    bit fin;

    phase = $urandom_range(0, period - 1);
    for (int k = 0; k < MAXC; k++) begin
      pul[k] = ((k + phase) % period) < width;
      set_idle(k);
      e_ack[k] = 0;
      d_we[k] = 0; d_start[k] = 0; d_stop[k] = 0; d_loop[k] = 0;
      d_addr[k] = 0; d_tempo[k] = 0; d_beats[k] = 0; d_len[k] = 0;
    end

    // A write on the start cycle must already be seen by the first FETCH.
    if (rand_io && $urandom_range(0, 1) == 1) begin
      d_we[0] = 1; d_addr[0] = $urandom_range(0, DEPTH - 1);
      d_tempo[0] = $urandom_range(0, 7); d_beats[0] = $urandom_range(0, 4);
      m_tempo[d_addr[0]] = d_tempo[0];
      m_beats[d_addr[0]] = d_beats[0];
      e_ack[1] = 1;
    end
    sum_beats = 0;
    for (int i = 0; i < len; i++) sum_beats += m_beats[i];

    // Build the expected schedule step by step.
    t = 1; st = 0; fin = 0; done_cyc = -1;
    while (!fin && t < MAXC - 3) begin
      e_busy[t] = 1; e_grst[t] = 1; s_care[t] = 0; e_step[t] = st; step_care[t] = 1;
      if (m_beats[st] != 0) begin
        cnt = 0;
        c = t + 1;
        while (c < MAXC - 3) begin
          e_busy[c] = 1; e_grst[c] = 0; e_s[c] = m_tempo[st]; s_care[c] = 1;
          e_step[c] = st; step_care[c] = 1;
          if (pulse_edge(c)) begin
            cnt++;
            e_tick[c+1] = 1;
            if (cnt == m_beats[st]) break;
          end
          c++;
        end
        t = c + 1;
      end else begin
        t = t + 1;
      end
      if (st < len - 1) st++;
      else if (lp) st = 0;
      else begin
        e_busy[t] = 0; e_grst[t] = 1; e_done[t] = 1; s_care[t] = 0;
        e_step[t] = st; step_care[t] = 1;
        done_cyc = t;
        fin = 1;
      end
    end

    stop_at = -1;
    if (stop_sel == -2 && done_cyc > 1) stop_at = done_cyc - 1;
    else if (stop_sel == -3) stop_at = $urandom_range(1, 300);
    else if (stop_sel >= 1) stop_at = stop_sel;
    if (stop_at >= 1) begin
      d_stop[stop_at] = 1;
      for (int k = stop_at + 1; k < MAXC; k++) set_idle(k);
    end

    last = 0;
    for (int k = 0; k < MAXC; k++)
      if (e_busy[k] != 0 || e_done[k] != 0 || e_tick[k] != 0) last = k;
    endc = (last + 3 > MAXC - 2) ? MAXC - 2 : last + 3;

    if (rand_io) begin
      for (int k = 1; k <= endc; k++) begin
        d_loop[k] = $urandom_range(0, 1);
        d_len[k]  = $urandom_range(0, 15);
        if (e_busy[k] != 0) d_start[k] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) == 0) begin
          d_we[k] = 1; d_addr[k] = $urandom_range(0, DEPTH - 1);
          d_tempo[k] = $urandom_range(0, 7); d_beats[k] = $urandom_range(0, 4);
          if (e_busy[k] == 0 && e_done[k] == 0) begin
            m_tempo[d_addr[k]] = d_tempo[k];
            m_beats[d_addr[k]] = d_beats[k];
            e_ack[k+1] = 1;
          end
        end
      end
    end

    obs_ticks = 0;
    obs_done  = 0;
    for (int k = 0; k <= endc; k++) begin
      cfg_we = d_we[k]; cfg_addr = d_addr[k][ADDR_W-1:0];
      cfg_tempo = d_tempo[k][2:0]; cfg_beats = d_beats[k][BEAT_W-1:0];
      start   = (k == 0) ? 1'b1 : d_start[k];
      seq_len = (k == 0) ? len[ADDR_W:0] : d_len[k][ADDR_W:0];
      loop    = (k == 0) ? lp : d_loop[k];
      stop    = d_stop[k];
      beat_pulse = pul[k];
      @(negedge clk);
      check_val("busy", busy, e_busy[k]);
      check_val("gen_reset", gen_reset, e_grst[k]);
      check_val("done", done, e_done[k]);
      check_val("beat_tick", beat_tick, e_tick[k]);
      check_val("cfg_ack", cfg_ack, e_ack[k]);
      if (s_care[k]) check_val("S", S, e_s[k]);
      if (step_care[k]) check_val("step", step, e_step[k]);
      if (beat_tick === 1'b1) obs_ticks++;
      if (done === 1'b1) obs_done++;
      next_cycle();
    end
    quiet_inputs();
    next_cycle();
    if (!lp && stop_at < 0) begin
      check_val("tick_total", obs_ticks, sum_beats);
      check_val("done_total", obs_done, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_lens [3];
    int len, per, wid, ssel;
    bit lp;

    quiet_inputs();
    reset = 1'b1;
    next_cycle();
    do_reset();

    // Two-step pattern, single pass
    cfg_write(0, 7, 3);
    cfg_write(1, 2, 2);
    run_seq(2, 1'b0, 10, 1, -1, 1'b0);
    // Same pattern looping, stopped after about twelve edges
    run_seq(2, 1'b1, 10, 1, 125, 1'b0);
    // Stop coinciding with the final beat edge
    run_seq(2, 1'b0, 10, 4, -2, 1'b0);

    // Skipped middle step
    cfg_write(1, 5, 0);
    cfg_write(2, 6, 2);
    run_seq(3, 1'b0, 7, 3, -1, 1'b0);

    // Config traffic and start/loop/len noise while busy, then replay
    run_seq(3, 1'b0, 6, 2, -1, 1'b1);
    run_seq(3, 1'b0, 5, 1, -1, 1'b0);

    // Invalid lengths are ignored
    bad_lens = '{0, 9, 15};
    foreach (bad_lens[i]) begin
      seq_len = bad_lens[i][ADDR_W:0];
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      check_val("badlen_busy", busy, 0);
      check_val("badlen_gen_reset", gen_reset, 1);
      next_cycle();
    end

    // Reset in the middle of a RUN, then replay the cleared table
    cfg_write(0, 4, 5);
    seq_len = 4'd1;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    @(negedge clk);
    check_val("mid_busy", busy, 1);
    check_val("mid_gen_reset", gen_reset, 0);
    check_val("mid_S", S, 4);
    next_cycle();
    do_reset();
    run_seq(5, 1'b0, 4, 2, -1, 1'b0);

    // Randomised runs over a random table
    for (int i = 0; i < DEPTH; i++)
      cfg_write(i, $urandom_range(0, 7), $urandom_range(0, 4));
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(1, DEPTH);
      lp  = $urandom_range(0, 1);
      per = $urandom_range(2, 10);
      wid = $urandom_range(1, per - 1);
      if (lp) ssel = -3;
      else ssel = ($urandom_range(0, 3) == 0) ? -3 : -1;
      run_seq(len, lp, per, wid, ssel, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Programmable tempo sequencer that drives the tempo-select input `S` and the reset of the beat generator `top`. It holds a small pattern table of {tempo code, beat count} steps and plays them in order. For each step it counts rising edges of the generator's `pulse`, then advances, optionally looping. It sits between the control/config interface and the beat generator.

## Interface
- `DEPTH`, 8: number of pattern entries (power of two, ≥2).
- `BEAT_W`, 8: width of per-step beat count.
- `ADDR_W`, clog2(DEPTH): derived localparam, not overridable.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_we` in 1: pattern-entry write strobe.
- `cfg_addr` in ADDR_W: entry index.
- `cfg_tempo` in 3: tempo code for the entry.
- `cfg_beats` in BEAT_W: beats for the entry.
- `cfg_ack` out 1: write accepted, registered, one cycle.
- `seq_len` in ADDR_W+1: number of steps to play, 1..DEPTH.
- `loop` in 1: restart at step 0 after the last step.
- `start` in 1: begin sequence (level sampled, acts when idle).
- `stop` in 1: abort sequence.
- `beat_pulse` in 1: `pulse` from the beat generator.
- `S` out 3: tempo select to the generator.
- `gen_reset` out 1: reset to the generator.
- `step` out ADDR_W: current step index.
- `busy` out 1: sequence active.
- `done` out 1: one-cycle end-of-sequence strobe (non-loop only).
- `beat_tick` out 1: one-cycle strobe per counted beat.

## Operation
- States: IDLE, FETCH, RUN, DONE.
- IDLE:
  - Outputs: `gen_reset`=1, `S`=0, `busy`=0.
  - `start` with 1 ≤ `seq_len` ≤ DEPTH: latch len and loop, set `step`=0, go to FETCH.
  - `start` with `seq_len`=0 or `seq_len`>DEPTH is ignored.
- FETCH (1 cycle):
  - `busy`=1, `gen_reset`=1.
  - Load `S` ← tempo[step] and remaining ← beats[step].
  - beats=0 means skip the step: apply the step-end rule instead of entering RUN.
- RUN:
  - `gen_reset`=0.
  - Beat edge = `beat_pulse` & ~prev, where prev is `beat_pulse` registered every cycle. Edges count only in RUN.
  - On each edge: decrement remaining and raise `beat_tick` the next cycle.
  - An edge with remaining=1 ends the step.
- Step-end rule:
  - If `step` < len−1: `step`+1, go to FETCH.
  - Else if loop: `step`=0, go to FETCH.
  - Else go to DONE.
- DONE (1 cycle): `done`=1, `gen_reset`=1, `busy`=0, `S` holds. Then IDLE with `S`=0.
- Stop:
  - In FETCH/RUN/DONE, `stop` sends the block to IDLE next cycle, with no `done`.
  - `stop` beats a simultaneous beat edge; `start` while busy is ignored.
- Config writes:
  - Accepted only in IDLE; `cfg_ack`=1 the following cycle. Ignored otherwise, with `cfg_ack`=0.
  - A write in the same IDLE cycle as `start` is visible to the first FETCH.
- Reset values:
  - Outputs: `S`=0, `gen_reset`=1, `step`=0, `busy`=0, `done`=0, `beat_tick`=0, `cfg_ack`=0.
  - Internal: all pattern entries cleared to 0, prev=0, state IDLE.
  - Reset mid-sequence has the same effect, overriding everything.
- Arithmetic: remaining is a BEAT_W-bit down-counter that never wraps. `step` compares against the latched len−1, computed in ADDR_W+1 bits.

## Timing
- `start` sampled at edge T:
  - T+1: FETCH (`busy`=1, `gen_reset`=1).
  - T+2: first RUN cycle, with `S` valid and `gen_reset`=0.
- Step change:
  - The final beat edge is sampled at E.
  - E+1: FETCH, with `gen_reset` high for exactly one cycle so each step starts phase-aligned.
  - E+2: RUN at the new tempo.
  - A skipped (beats=0) step costs one FETCH cycle.
- Final step, non-loop: last edge at E, DONE at E+1 (`done`=1), IDLE at E+2.
- `beat_tick` lags the counted edge by one cycle.

## Structure
- Shared package `beat_pkg`:
  - `TEMPO_W`=3.
  - State enum {IDLE, FETCH, RUN, DONE}.
  - Packed struct `beat_entry_t` {tempo, beats}.
- Sub-module `beat_pattern_mem`:
  - DEPTH×`beat_entry_t` register array.
  - Synchronous write, combinational read, sync clear on reset.
- Edge detect and FSM live in `beat_sequencer`.

## Test plan
- Write entries 0:{7,3} and 1:{2,2}, `seq_len`=2, `loop`=0, `start`; model pulses every 10 cycles:
  - `S`=7 for 3 beats, a one-cycle `gen_reset` gap, then `S`=2 for 2 beats.
  - `done` pulses once, `beat_tick` count = 5, then IDLE with `S`=0.
- Same pattern with `loop`=1 through 12 edges: `step` sequence 0,0,0,1,1,0,0,0,1,1,0,0; `done` never asserts.
- `stop` in the same cycle as the final beat edge: IDLE next cycle, `done`=0, `gen_reset`=1.
- Entry 1 beats=0, `seq_len`=3: step 1 skipped in one FETCH cycle; `S` never shows tempo[1] in RUN.
- `cfg_we` while busy: no `cfg_ack`, pattern unchanged on replay. `start` with `seq_len`=0 or 9 (DEPTH=8): stays IDLE.
- `reset` mid-RUN, then replay with no writes: all-zero pattern, every step skipped; the sequence completes with `done` after seq_len+1 cycles.
